// File: rtl/cbus_arbiter_n_if.sv
// Bundled cbus signals between N requesting masters, the arbiter and the downstream port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface cbus_arbiter_n_if #(
  parameter int unsigned NPORT = 4,
  parameter int unsigned AW    = 64,
  parameter int unsigned DW    = 64,
  parameter int unsigned LENW  = 4
);
  logic [NPORT-1:0]        ireq_valid;
  logic [NPORT-1:0]        ireq_is_write;
  logic [NPORT*3-1:0]      ireq_size;
  logic [NPORT*AW-1:0]     ireq_addr;
  logic [NPORT*DW/8-1:0]   ireq_strobe;
  logic [NPORT*DW-1:0]     ireq_data;
  logic [NPORT*LENW-1:0]   ireq_len;
  logic [NPORT-1:0]        iresp_ready;
  logic [NPORT-1:0]        iresp_last;
  logic [DW-1:0]           iresp_data;

  logic                    oreq_valid;
  logic                    oreq_is_write;
  logic [2:0]              oreq_size;
  logic [AW-1:0]           oreq_addr;
  logic [DW/8-1:0]         oreq_strobe;
  logic [DW-1:0]           oreq_data;
  logic [LENW-1:0]         oreq_len;
  logic                    oresp_ready;
  logic                    oresp_last;
  logic [DW-1:0]           oresp_data;

  modport slave (
    input  ireq_valid, ireq_is_write, ireq_size, ireq_addr, ireq_strobe, ireq_data, ireq_len,
    output iresp_ready, iresp_last, iresp_data,
    output oreq_valid, oreq_is_write, oreq_size, oreq_addr, oreq_strobe, oreq_data, oreq_len,
    input  oresp_ready, oresp_last, oresp_data
  );

  modport master (
    output ireq_valid, ireq_is_write, ireq_size, ireq_addr, ireq_strobe, ireq_data, ireq_len,
    input  iresp_ready, iresp_last, iresp_data,
    input  oreq_valid, oreq_is_write, oreq_size, oreq_addr, oreq_strobe, oreq_data, oreq_len,
    output oresp_ready, oresp_last, oresp_data
  );
endinterface

// File: rtl/cbus_arbiter_n.sv
// N-master cbus arbiter: round-robin or fixed-priority grant, holds the grant for a whole
// burst until downstream last, and flags burst-length mismatches on proto_err.
module cbus_arbiter_n #(
  parameter int unsigned NPORT = 4,
  parameter int unsigned AW    = 64,
  parameter int unsigned DW    = 64,
  parameter int unsigned LENW  = 4,
  parameter int unsigned RR    = 1,
  parameter int unsigned IW    = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic            clk,
  input  logic            reset,
  cbus_arbiter_n_if.slave bus,
  output logic            grant_valid,
  output logic [IW-1:0]   grant_idx,
  output logic            proto_err
);
  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = LENW + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_d;
  logic [IW-1:0]   win;
  logic            any_req;
  int unsigned     cand;
  logic [LENW-1:0] len_g;

  // Winner search: scan upward from the pointer (RR) or from index 0 (fixed priority).
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    cand    = 0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      cand = (RR != 0) ? ((32'(ptr_q) + i) % NPORT) : i;
      if (!any_req && bus.ireq_valid[IW'(cand)]) begin
        any_req = 1'b1;
        win     = IW'(cand);
      end
    end
  end

  assign len_g = bus.ireq_len[32'(grant_q) * LENW +: LENW];

  // Next-state, request mux and response steering.
  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    ptr_d             = ptr_q;
    cnt_d             = cnt_q;
    err_d             = 1'b0;
    bus.oreq_valid    = 1'b0;
    bus.oreq_is_write = 1'b0;
    bus.oreq_size     = '0;
    bus.oreq_addr     = '0;
    bus.oreq_strobe   = '0;
    bus.oreq_data     = '0;
    bus.oreq_len      = '0;
    bus.iresp_ready   = '0;
    bus.iresp_last    = '0;
    bus.iresp_data    = '0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BUSY;
          grant_d = win;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        bus.oreq_valid             = bus.ireq_valid[grant_q];
        bus.oreq_is_write          = bus.ireq_is_write[grant_q];
        bus.oreq_size              = bus.ireq_size[32'(grant_q) * 3 +: 3];
        bus.oreq_addr              = bus.ireq_addr[32'(grant_q) * AW +: AW];
        bus.oreq_strobe            = bus.ireq_strobe[32'(grant_q) * SW +: SW];
        bus.oreq_data              = bus.ireq_data[32'(grant_q) * DW +: DW];
        bus.oreq_len               = len_g;
        bus.iresp_ready[grant_q]   = bus.oresp_ready;
        bus.iresp_last[grant_q]    = bus.oresp_last;
        bus.iresp_data             = bus.oresp_data;
        if (bus.oresp_ready) begin
          if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
          // Transaction always ends on last; the count only feeds the error check.
          if (bus.oresp_last) begin
            err_d   = (cnt_q != CW'(len_g));
            state_d = IDLE;
            if (RR != 0) ptr_d = (grant_q == IW'(NPORT - 1)) ? '0 : grant_q + IW'(1);
          end else begin
            err_d = (cnt_q == CW'(len_g));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and grant registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      proto_err <= err_d;
    end
  end

  assign grant_valid = (state_q == BUSY);
  assign grant_idx   = grant_q;
endmodule
